// File: rtl/sevenseg_scanner_pkg.sv
// Shared constants for the seven-segment scanner: segment bit order,
// blank pattern and the hex decode table.
package sevenseg_scanner_pkg;

  // Segment bit positions; the bus is {g,f,e,d,c,b,a}.
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;

  typedef logic [SEG_G:SEG_A] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Active-high patterns for 0..F (lowercase b and d avoid confusion with 8 and 0).
  localparam seg_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sevenseg_scanner_if.sv
// Application-side bus of the scanner: value/load/blank control in,
// segment/digit pins and status out.
interface sevenseg_scanner_if
  import sevenseg_scanner_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                blank_lz;
  seg_t                segments;
  logic [DIGITS-1:0]   digit_en;
  logic                pending;
  logic                frame;

  modport master (output value, load, blank_lz,
                  input  segments, digit_en, pending, frame);
  modport slave  (input  value, load, blank_lz,
                  output segments, digit_en, pending, frame);
endinterface

// File: rtl/sevenseg_scanner_dec.sv
// Combinational hex-to-segment decoder with ripple-blank input: a zero
// nibble is blanked when every more significant digit was also blanked.
module sevenseg_scanner_dec
  import sevenseg_scanner_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       rbi,
  output seg_t       seg
);
  assign seg = (rbi && nib == 4'h0) ? SEG_BLANK : SEG_HEX[nib];
endmodule

// File: rtl/sevenseg_scanner.sv
// Time-multiplexed seven-segment driver: shadow/display double buffer
// swapped only at frame boundaries, one shared decoder, dead time at the
// start of every digit slot and leading-zero suppression.
module sevenseg_scanner
  import sevenseg_scanner_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 1000,
  parameter int DEAD    = 2
)(
  input  logic               clk,
  input  logic               reset_n,
  sevenseg_scanner_if.slave  bus
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PSC_DEAD = PW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]            psc;
  logic [IW-1:0]            idx;
  logic [DIGITS-1:0][3:0]   shadow, display;
  logic                     pend;
  logic [DIGITS-1:0]        rb;
  logic                     wrap, fb, dead, rbi;
  logic [3:0]               nib;
  seg_t                     seg_dec;

  assign wrap = (psc == PSC_LAST);
  assign fb   = wrap && (idx == IDX_LAST);
  assign dead = (psc < PSC_DEAD);

  // Ripple-blank chain from the MSD down; rb[i] is the blank-in of digit i.
  assign rb[DIGITS-1] = bus.blank_lz;
  for (genvar i = DIGITS - 1; i > 0; i--) begin : g_rb
    assign rb[i-1] = rb[i] & (display[i] == 4'h0);
  end

  // Digit 0 never blanks so an all-zero value still reads "0".
  assign nib = display[idx];
  assign rbi = (idx == '0) ? 1'b0 : rb[idx];

  sevenseg_scanner_dec u_dec (
    .nib (nib),
    .rbi (rbi),
    .seg (seg_dec)
  );

  // Prescaler and slot index; index advances once per prescaler wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc <= '0;
      idx <= '0;
    end else begin
      psc <= wrap ? '0 : psc + 1'b1;
      if (wrap) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Double buffer: load fills the shadow, frame boundary publishes it.
  // A load on the boundary cycle still publishes the old shadow and keeps
  // pending set for the newly captured value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow  <= '0;
      display <= '0;
      pend    <= 1'b0;
    end else begin
      if (fb && pend) display <= shadow;
      if (bus.load) begin
        shadow <= bus.value;
        pend   <= 1'b1;
      end else if (fb) begin
        pend   <= 1'b0;
      end
    end
  end

  // Registered pins; the dead window guarantees no two digits overlap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.segments <= SEG_BLANK;
      bus.digit_en <= '0;
      bus.frame    <= 1'b0;
    end else begin
      bus.segments <= dead ? SEG_BLANK : seg_dec;
      bus.digit_en <= dead ? '0 : DIGITS'(1) << idx;
      bus.frame    <= fb;
    end
  end

  assign bus.pending = pend;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Bench for sevenseg_scanner at DIGITS=4, CLK_DIV=8, DEAD=2.
module tb_sevenseg_scanner;
  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 8;
  localparam int DEAD    = 2;
  localparam int FRAME   = DIGITS * CLK_DIV;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  sevenseg_scanner_if #(.DIGITS(DIGITS)) bus();

  sevenseg_scanner #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     value;
    logic            bl;
    logic [3:0][6:0] seg;   // expected pattern per digit, [3] = MSD
  } vec_t;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] en;
    logic       frm;
  } exp_t;

  vec_t vecs [8];
  exp_t sbq [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns at the negedge of the cycle where frame is high.
  task automatic wait_frame(input string name);
    bit seen = 0;
    for (int n = 0; n < 4 * FRAME; n++) begin
      @(negedge clk);
      if (bus.frame === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no frame pulse within %0d cycles", name, 4 * FRAME);
    end
  endtask

  // Called at the frame-pulse cycle; checks the following FRAME cycles and
  // optionally pulses load after sampling cycle lc1/lc2.
  task automatic check_frame(input logic [3:0][6:0] seg, input int lc1, input logic [15:0] lv1,
                             input int lc2, input logic [15:0] lv2);
    exp_t e;
    int s, k;
    for (int c = 1; c <= FRAME; c++) begin
      s = (c - 1) / CLK_DIV;
      k = (c - 1) % CLK_DIV;
      e.frm = (c == FRAME);
      if (k < DEAD) begin
        e.seg = 7'h00;
        e.en  = 4'h0;
      end else begin
        e.seg = seg[s];
        e.en  = 4'(1 << s);
      end
      sbq.push_back(e);
    end
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("segments c%0d", c), 32'(bus.segments), 32'(e.seg));
      chk($sformatf("digit_en c%0d", c), 32'(bus.digit_en), 32'(e.en));
      chk($sformatf("frame c%0d", c), 32'(bus.frame), 32'(e.frm));
      if (c == 20 && lc1 >= 1 && lc1 < 20) chk("pending mid-frame", 32'(bus.pending), 32'd1);
      if (c == lc1) begin
        bus.value = lv1;
        bus.load  = 1'b1;
      end else if (c == lc2) begin
        bus.value = lv2;
        bus.load  = 1'b1;
      end else begin
        bus.load  = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    int last_frm;
    int zrun;
    logic [3:0] prev_en;

    vecs[0] = '{16'h12AF, 1'b0, {7'h06, 7'h5B, 7'h77, 7'h71}};
    vecs[1] = '{16'h0050, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}};
    vecs[2] = '{16'h0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[3] = '{16'h0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[4] = '{16'h8B0C, 1'b1, {7'h7F, 7'h7C, 7'h3F, 7'h39}};
    vecs[5] = '{16'h0D04, 1'b1, {7'h00, 7'h5E, 7'h3F, 7'h66}};
    vecs[6] = '{16'h3E96, 1'b0, {7'h4F, 7'h79, 7'h6F, 7'h7D}};
    vecs[7] = '{16'h0007, 1'b1, {7'h00, 7'h00, 7'h00, 7'h27}};

    bus.value = '0;
    bus.load = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset state
    #23;
    chk("reset segments", 32'(bus.segments), 32'h0);
    chk("reset digit_en", 32'(bus.digit_en), 32'h0);
    chk("reset pending", 32'(bus.pending), 32'h0);
    chk("reset frame", 32'(bus.frame), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // First value: load, see pending, wait for the publishing frame
    bus.blank_lz = vecs[0].bl;
    bus.value = vecs[0].value;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    chk("pending after load", 32'(bus.pending), 32'd1);
    wait_frame("first frame");
    chk("pending at first frame", 32'(bus.pending), 32'd0);

    // Table vectors; each frame preloads the next value mid-frame.
    // The last one loads 1111 then 2222 within the same frame.
    for (int i = 0; i < 8; i++) begin
      bus.blank_lz = vecs[i].bl;
      if (i < 7) check_frame(vecs[i].seg, 10, vecs[i+1].value, -1, 16'h0);
      else       check_frame(vecs[i].seg, 5, 16'h1111, 15, 16'h2222);
      chk($sformatf("pending after frame %0d", i), 32'(bus.pending), 32'd0);
    end
    bus.blank_lz = 1'b0;

    // Frame shows 2222; load 4444 mid-frame then 5555 on the boundary cycle
    check_frame({4{7'h5B}}, 10, 16'h4444, 31, 16'h5555);
    chk("pending after boundary load", 32'(bus.pending), 32'd1);
    check_frame({4{7'h66}}, -1, 16'h0, -1, 16'h0);
    chk("pending after 4444 frame", 32'(bus.pending), 32'd0);
    check_frame({4{7'h6D}}, -1, 16'h0, -1, 16'h0);

    // Reset during slot 2
    for (int c = 1; c <= 20; c++) @(negedge clk);
    chk("slot2 digit_en before reset", 32'(bus.digit_en), 32'h4);
    chk("slot2 segments before reset", 32'(bus.segments), 32'h6D);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset segments", 32'(bus.segments), 32'h0);
    chk("async reset digit_en", 32'(bus.digit_en), 32'h0);
    chk("async reset pending", 32'(bus.pending), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.digit_en == 4'h0 && n < 4 * FRAME);
    chk("cycles to first digit after reset", 32'(n), 32'(DEAD + 1));
    chk("first digit_en after reset", 32'(bus.digit_en), 32'h1);
    chk("first segments after reset", 32'(bus.segments), 32'h3F);
    wait_frame("frame after reset");
    check_frame({4{7'h3F}}, -1, 16'h0, -1, 16'h0);

    // Free run with random loads and blank_lz
    last_frm = 0;
    zrun = 0;
    prev_en = 4'h8;
    for (int cyc = 0; cyc < 100 * FRAME; cyc++) begin
      if (cyc > 0) @(negedge clk);
      chk("digit_en onehot0", 32'($countones(bus.digit_en) <= 1), 32'd1);
      if (bus.digit_en != 4'h0) begin
        if (prev_en == 4'h0) chk("dead cycles before slot", 32'(zrun >= DEAD), 32'd1);
        else chk("no direct digit switch", 32'(bus.digit_en), 32'(prev_en));
        zrun = 0;
      end else begin
        zrun++;
      end
      prev_en = bus.digit_en;
      if (bus.frame === 1'b1 && cyc > 0) begin
        chk("frame period", 32'(cyc - last_frm), 32'(FRAME));
        last_frm = cyc;
      end
      bus.load = ($urandom_range(0, 7) == 0);
      bus.value = 16'($urandom);
      bus.blank_lz = 1'($urandom_range(0, 1));
    end
    bus.load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
